// File: rtl/kissp_sequencer_if.sv
// +--------------------------------------------------------------------+
// | kissp_sequencer_if : fetch, data, register-bank and status bundle   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

interface kissp_sequencer_if;
  logic               imem_req;
  logic        [31:0] imem_addr;
  logic               imem_ack;
  logic        [31:0] imem_rdata;
  logic               dmem_req;
  logic               dmem_we;
  logic               dmem_ack;
  logic        [4:0]  src1;
  logic        [4:0]  src2;
  logic        [4:0]  dst;
  logic signed [4:0]  imm;
  logic               op;
  logic               r_w;
  logic               r_src;
  logic        [31:0] src1_v;
  logic        [31:0] pc;
  logic               halted;
  logic               fault;

  // master = the sequencer; slave = memories and datapath
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    output src1, src2, dst, imm, op, r_w, r_src, pc, halted, fault,
    input  imem_ack, imem_rdata, dmem_ack, src1_v
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    input  src1, src2, dst, imm, op, r_w, r_src, pc, halted, fault,
    output imem_ack, imem_rdata, dmem_ack, src1_v
  );
endinterface

`default_nettype wire

// File: rtl/kissp_sequencer.sv
// +--------------------------------------------------------------------+
// | kissp_sequencer : multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit |
// | Option macro : KISSP_BRANCH_EN (makes opcode 4, BZ, legal)         |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module kissp_sequencer #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'h0000_0001
) (
  input  wire logic         clk,
  input  wire logic         rst,
  kissp_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  localparam logic [3:0] OPC_ADD  = 4'd0;
  localparam logic [3:0] OPC_SUB  = 4'd1;
  localparam logic [3:0] OPC_LD   = 4'd2;
  localparam logic [3:0] OPC_ST   = 4'd3;
`ifdef KISSP_BRANCH_EN
  localparam logic [3:0] OPC_BZ   = 4'd4;
`endif
  localparam logic [3:0] OPC_HALT = 4'd15;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        op_q, op_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  logic [3:0]  opcode;
  logic [31:0] pc_seq;
  logic        unused_bits;

  assign opcode      = instr_q[31:28];
  assign pc_seq      = pc_q + PC_STEP;
  assign unused_bits = ^instr_q[7:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    op_d     = op_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          // LD/ST address generation also needs the ALU adding
          op_d    = (bus.imem_rdata[31:28] != OPC_SUB);
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OPC_ADD, OPC_SUB: state_d = S_WB;
          OPC_LD, OPC_ST:   state_d = S_MEM;
          OPC_HALT: begin
            pc_d     = pc_seq;
            halted_d = 1'b1;
            state_d  = S_STOP;
          end
`ifdef KISSP_BRANCH_EN
          OPC_BZ: begin
            // offset is relative to the BZ address still held in pc_q
            pc_d    = (bus.src1_v == 32'd0)
                      ? pc_q + {{27{instr_q[12]}}, instr_q[12:8]}
                      : pc_seq;
            state_d = S_FETCH;
          end
`endif
          default: begin
            fault_d = 1'b1;
            pc_d    = pc_seq;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (opcode == OPC_ST) begin
            pc_d    = pc_seq;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        pc_d    = pc_seq;
        state_d = S_FETCH;
      end
      S_STOP:   state_d = S_STOP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_RESET;
      instr_q  <= 32'd0;
      op_q     <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      op_q     <= op_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.imem_req  = (state_q == S_FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.dmem_req  = (state_q == S_MEM);
  assign bus.dmem_we   = (state_q == S_MEM) && (opcode == OPC_ST);
  assign bus.r_w       = (state_q == S_WB);
  assign bus.r_src     = (state_q == S_WB) && (opcode == OPC_LD);
  assign bus.dst       = instr_q[27:23];
  assign bus.src1      = instr_q[22:18];
  assign bus.src2      = instr_q[17:13];
  assign bus.imm       = $signed(instr_q[12:8]);
  assign bus.op        = op_q;
  assign bus.pc        = pc_q;
  assign bus.halted    = halted_q;
  assign bus.fault     = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_kissp_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_kissp_sequencer : scoreboard bench for kissp_sequencer           |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_kissp_sequencer;

  typedef struct {
    bit         is_mem;
    logic [4:0] dst;
    logic [4:0] src1;
    logic [4:0] src2;
    logic [4:0] imm;
    logic       op;
    logic       r_src;
    logic       we;
    int         len;
  } ev_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   last_fetch = 0;
  int   dlen = 0;
  logic dwe_seen = 1'b0;
  ev_t  sb[$];

  kissp_sequencer_if bus_a ();
  kissp_sequencer_if bus_b ();

  kissp_sequencer #(.PC_RESET(32'h0000_0010), .PC_STEP(32'd1)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  kissp_sequencer #(.PC_RESET(32'hFFFF_FFFF), .PC_STEP(32'd1)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] o, input logic [4:0] d,
                                      input logic [4:0] s1, input logic [4:0] s2,
                                      input logic [4:0] im);
    return {o, d, s1, s2, im, 8'hA5};
  endfunction

  function automatic ev_t wb_ev(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [4:0] im, input logic o, input logic rs);
    ev_t e;
    e.is_mem = 1'b0; e.dst = d; e.src1 = s1; e.src2 = s2; e.imm = im;
    e.op = o; e.r_src = rs; e.we = 1'b0; e.len = 0;
    return e;
  endfunction

  function automatic ev_t mem_ev(input logic w, input int l);
    ev_t e;
    e = wb_ev(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    e.is_mem = 1'b1; e.we = w; e.len = l;
    return e;
  endfunction

  // Entered and left on a falling edge; lat < 0 skips the latency check.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] ins, input int delay, input int lat);
    int n;
    n = 0;
    while (bus_a.imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("fetch_timeout", 32'(n < 50), 32'd1);
    if (lat >= 0) check("latency", 32'(cyc - last_fetch), 32'(lat));
    last_fetch = cyc;
    check("imem_addr", bus_a.imem_addr, addr);
    repeat (delay) @(negedge clk);
    check("imem_req_held", 32'(bus_a.imem_req), 32'd1);
    bus_a.imem_rdata = ins;
    bus_a.imem_ack   = 1'b1;
    @(negedge clk);
    bus_a.imem_ack   = 1'b0;
  endtask

  task automatic dserve(input logic exp_we, input int delay);
    int n;
    n = 0;
    while (bus_a.dmem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("dmem_timeout", 32'(n < 50), 32'd1);
    check("dmem_we", 32'(bus_a.dmem_we), 32'(exp_we));
    repeat (delay) @(negedge clk);
    bus_a.dmem_ack = 1'b1;
    @(negedge clk);
    bus_a.dmem_ack = 1'b0;
  endtask

  // Scoreboard monitor: data requests are compared when they end, write-backs on the strobe.
  always @(negedge clk) begin
    ev_t e;
    if (!rst_a) begin
      if (bus_a.r_w || bus_a.dmem_req)
        check("rw_dmem_exclusive", 32'(bus_a.r_w & bus_a.dmem_req), 32'd0);
      if (bus_a.dmem_req) begin
        dlen     = dlen + 1;
        dwe_seen = bus_a.dmem_we;
      end else if (dlen != 0) begin
        if (sb.size() == 0) begin
          check("unexpected_dmem", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ev_kind_mem", 32'(e.is_mem), 32'd1);
          check("dmem_len", 32'(dlen), 32'(e.len));
          check("dmem_we_seen", 32'(dwe_seen), 32'(e.we));
        end
        dlen = 0;
      end
      if (bus_a.r_w) begin
        if (sb.size() == 0) begin
          check("unexpected_wb", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ev_kind_wb", 32'(e.is_mem), 32'd0);
          check("wb_dst", 32'(bus_a.dst), 32'(e.dst));
          check("wb_src1", 32'(bus_a.src1), 32'(e.src1));
          check("wb_src2", 32'(bus_a.src2), 32'(e.src2));
          check("wb_imm", 32'($unsigned(bus_a.imm)), 32'(e.imm));
          check("wb_op", 32'(bus_a.op), 32'(e.op));
          check("wb_r_src", 32'(bus_a.r_src), 32'(e.r_src));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int          seen;
    int          n;
    bus_a.imem_ack = 1'b0; bus_a.imem_rdata = 32'd0; bus_a.dmem_ack = 1'b0; bus_a.src1_v = 32'd0;
    bus_b.imem_ack = 1'b0; bus_b.imem_rdata = 32'd0; bus_b.dmem_ack = 1'b0; bus_b.src1_v = 32'd0;

    repeat (3) @(negedge clk);
    check("rst_pc", bus_a.pc, 32'h10);
    check("rst_imem_req", 32'(bus_a.imem_req), 32'd0);
    check("rst_dmem_req", 32'(bus_a.dmem_req), 32'd0);
    check("rst_r_w", 32'(bus_a.r_w), 32'd0);
    check("rst_op", 32'(bus_a.op), 32'd0);
    check("rst_fields", {12'd0, bus_a.dst, bus_a.src1, bus_a.src2, $unsigned(bus_a.imm)}, 32'd0);
    check("rst_flags", {30'd0, bus_a.halted, bus_a.fault}, 32'd0);
    rst_a = 1'b0;

    // ADD, SUB (with one fetch wait), LD with slow data ack, ST
    sb.push_back(wb_ev(5'd3, 5'd4, 5'd5, 5'h1D, 1'b1, 1'b0));
    fetch(32'h10, enc(4'd0, 5'd3, 5'd4, 5'd5, 5'h1D), 0, -1);
    sb.push_back(wb_ev(5'd6, 5'd1, 5'd2, 5'h07, 1'b0, 1'b0));
    fetch(32'h11, enc(4'd1, 5'd6, 5'd1, 5'd2, 5'h07), 1, 4);
    sb.push_back(mem_ev(1'b0, 4));
    sb.push_back(wb_ev(5'd7, 5'd8, 5'd0, 5'h02, 1'b1, 1'b1));
    fetch(32'h12, enc(4'd2, 5'd7, 5'd8, 5'd0, 5'h02), 0, 5);
    dserve(1'b0, 3);
    sb.push_back(mem_ev(1'b1, 1));
    fetch(32'h13, enc(4'd3, 5'd9, 5'd10, 5'd0, 5'h01), 0, 8);
    dserve(1'b1, 0);

    // illegal opcode, then eleven ADDs with fault held
    fetch(32'h14, enc(4'd7, 5'd1, 5'd1, 5'd1, 5'd1), 0, 4);
    for (int i = 0; i < 11; i++) begin
      sb.push_back(wb_ev(5'(i), 5'(i + 1), 5'(i + 2), 5'(i), 1'b1, 1'b0));
      fetch(32'h15 + 32'(i), enc(4'd0, 5'(i), 5'(i + 1), 5'(i + 2), 5'(i)), 0, (i == 0) ? 3 : 4);
      if (i == 0) check("fault_set", 32'(bus_a.fault), 32'd1);
    end
    check("fault_sticky", 32'(bus_a.fault), 32'd1);

    // BZ imm=-2 at 0x20, taken then not taken
    bus_a.src1_v = 32'd0;
    fetch(32'h20, enc(4'd4, 5'd0, 5'd2, 5'd0, 5'h1E), 0, 4);
`ifdef KISSP_BRANCH_EN
    sb.push_back(wb_ev(5'd1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0));
    fetch(32'h1E, enc(4'd0, 5'd1, 5'd0, 5'd0, 5'd0), 0, 3);
    sb.push_back(wb_ev(5'd2, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0));
    fetch(32'h1F, enc(4'd0, 5'd2, 5'd0, 5'd0, 5'd0), 0, 4);
    bus_a.src1_v = 32'd5;
    fetch(32'h20, enc(4'd4, 5'd0, 5'd2, 5'd0, 5'h1E), 0, 4);
    a = 32'h21;
`else
    bus_a.src1_v = 32'd5;
    fetch(32'h21, enc(4'd4, 5'd0, 5'd2, 5'd0, 5'h1E), 0, 3);
    a = 32'h22;
`endif

    // ST followed by HALT
    sb.push_back(mem_ev(1'b1, 1));
    fetch(a, enc(4'd3, 5'd4, 5'd5, 5'd0, 5'd0), 0, 3);
    dserve(1'b1, 0);
    fetch(a + 32'd1, enc(4'd15, 5'd0, 5'd0, 5'd0, 5'd0), 0, 4);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_a.imem_req || bus_a.dmem_req) seen++;
    end
    check("no_req_after_halt", 32'(seen), 32'd0);
    check("halted", 32'(bus_a.halted), 32'd1);
    check("halt_pc", bus_a.pc, a + 32'd2);

    // reset during a fetch wait, then a stale ack
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("halted_cleared", 32'(bus_a.halted), 32'd0);
    sb.push_back(wb_ev(5'd11, 5'd12, 5'd13, 5'd3, 1'b1, 1'b0));
    fetch(32'h10, enc(4'd0, 5'd11, 5'd12, 5'd13, 5'd3), 0, -1);
    n = 0;
    while (bus_a.imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("fetch2_addr", bus_a.imem_addr, 32'h11);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check("rst_mid_imem_req", 32'(bus_a.imem_req), 32'd0);
    check("rst_mid_pc", bus_a.pc, 32'h10);
    rst_a = 1'b0;
    bus_a.imem_rdata = enc(4'd1, 5'd20, 5'd21, 5'd22, 5'd0);
    bus_a.imem_ack   = 1'b1;
    @(negedge clk);
    bus_a.imem_ack   = 1'b0;
    sb.push_back(wb_ev(5'd10, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0));
    fetch(32'h10, enc(4'd0, 5'd10, 5'd1, 5'd2, 5'd4), 0, -1);
    repeat (6) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    // PC wrap on the second instance
    rst_b = 1'b0;
    n = 0;
    while (bus_b.imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wrap_fetch_addr", bus_b.imem_addr, 32'hFFFF_FFFF);
    bus_b.imem_rdata = enc(4'd0, 5'd1, 5'd2, 5'd3, 5'd0);
    bus_b.imem_ack   = 1'b1;
    @(negedge clk);
    bus_b.imem_ack   = 1'b0;
    n = 0;
    while (bus_b.imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wrap_timeout", 32'(n < 50), 32'd1);
    check("wrap_pc", bus_b.pc, 32'd0);
    check("wrap_imem_addr", bus_b.imem_addr, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/kissp_sequencer.md
# kissp_sequencer

Multi-cycle control unit for the kissp core. It fetches instructions over a request/acknowledge port, decodes them into the register-bank, ALU and memory control signals, and steps each instruction through FETCH → DECODE → EXEC → MEM → WB. It owns the program counter and a sticky fault/halt status. It sits between the instruction/data memories and the `registers`/`alu` datapath inside `processor`.

## Interface
Parameters:
- `PC_RESET`, default 0: PC value loaded on reset.
- `PC_STEP`, default 1: PC increment per sequential instruction (word addressing).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_ack` in 1: fetch data valid.
- `imem_rdata` in 32: instruction word.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data write (ST) when 1, read when 0.
- `dmem_ack` in 1: data access complete.
- `src1`, `src2`, `dst` out 5 each: register-bank addresses.
- `imm` out 5 signed: immediate to the ALU third operand.
- `op` out 1: ALU op; 1 = add, 0 = subtract.
- `r_w` out 1: register write strobe.
- `r_src` out 1: write-back source; 0 = ALU, 1 = data memory.
- `src1_v` in 32: register value of `src1`, used for branch test.
- `pc` out 32: program counter.
- `halted` out 1: sticky; set after HALT is retired.
- `fault` out 1: sticky; set on an illegal opcode.

## Operation
- Encoding: [31:28] opcode, [27:23] dst, [22:18] src1, [17:13] src2, [12:8] imm; bits [7:0] are ignored.
- Opcodes:
  - 0 ADD (op=1), 1 SUB (op=0): rd = ALU result.
  - 2 LD: rd = mem[ALU result].
  - 3 ST: mem[ALU result] = reg[dst].
  - 4 BZ: see Configuration.
  - 15 HALT.
  - Any other opcode sets `fault` and behaves as a NOP.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, STOP.
- Transitions:
  - IDLE → FETCH on the cycle after reset deasserts.
  - FETCH holds `imem_req`=1 until `imem_ack`; the instruction latches on the ack edge, then → DECODE.
  - DECODE drives the field outputs from the latched instruction; these stay stable until the next FETCH. Then → EXEC.
  - EXEC → MEM for LD/ST. → WB for ADD/SUB. → STOP for HALT. → FETCH for BZ, NOP or illegal opcodes, with the PC update applied.
  - MEM holds `dmem_req`=1 (`dmem_we`=1 for ST) until `dmem_ack`. ST then → FETCH; LD → WB.
  - WB pulses `r_w`=1 for exactly one cycle (`r_src`=1 for LD), applies the PC update, then → FETCH.
- PC update: `pc <= pc + PC_STEP`, 32-bit wrap-around (0xFFFFFFFF + 1 = 0).
- STOP is terminal until `rst`. Nothing is requested; `halted`=1; `pc` frozen at the HALT address + PC_STEP.
- `fault` does not stop execution.

## Timing
- Reset values (all synchronous):
  - `pc`=PC_RESET.
  - State IDLE.
  - `imem_req`, `dmem_req`, `dmem_we`, `r_w`, `r_src`, `op`, `halted`, `fault` = 0.
  - `src1`, `src2`, `dst`, `imm` = 0.
- Latency with ack in the first request cycle: ADD/SUB 4 cycles; LD 5; ST 4; BZ/NOP/illegal 3. Each extra wait cycle on an ack adds 1 cycle.
- Requests are level signals, held continuously until ack. An ack while no request is outstanding is ignored.
- `r_w` and `dmem_req` are never asserted in the same cycle.
- Reset mid-request drops `imem_req`/`dmem_req` in the same edge. Any later ack is ignored.
- `rst` has priority over every transition and over sticky flag updates.

## Configuration
- `KISSP_BRANCH_EN` defined: BZ is legal. In EXEC, if `src1_v`==0 then `pc <= pc + sign-extended imm`, otherwise `pc <= pc + PC_STEP`. The offset is relative to the BZ address. imm=0 on a taken branch loops on itself.
- Not defined: opcode 4 is illegal; it sets `fault` and advances the PC by PC_STEP.

## Test plan
- Reset with PC_RESET=0x10, ack held 1, then ADD at 0x10: after 4 cycles `r_w` has pulsed once with dst/src1/src2/imm matching the encoding, and `pc`=0x11.
- LD with `dmem_ack` delayed 3 cycles: `dmem_req` held for 4 cycles, `dmem_we`=0, `r_w` with `r_src`=1 one cycle after the ack, total 8 cycles.
- ST followed by HALT: one request with `dmem_we`=1 and no `r_w`. Then `halted`=1, no further `imem_req`, and `pc` = HALT address + 1.
- Opcode 7: `fault`=1, no `r_w`/`dmem_req`, and the next fetch is at pc+1. `fault` stays set across 10 further instructions.
- With KISSP_BRANCH_EN, BZ imm=-2 at pc=0x20 and `src1_v`=0: next fetch at 0x1E. With `src1_v`=5: next fetch at 0x21.
- Assert `rst` during a FETCH wait: the next cycle has `imem_req`=0 and `pc`=PC_RESET, and a stale ack arriving 1 cycle later is ignored. Separately, a wrap test with pc=0xFFFFFFFF executing ADD gives `pc`=0.
